// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient bank with swap sequencing and sample gating.
// Optional delay-line flush after each swap is enabled by defining FIR_CTRL_FLUSH_EN.
module fir_coeff_ctrl #(
    parameter int INPUT_WORD_SIZE = 16,
    parameter int COEFF_WORD_SIZE = 16,
    parameter int N_COEFFS        = 5,
    localparam int AW             = $clog2(N_COEFFS)
) (
    input  logic                                clk,
    input  logic                                arst_n,
    input  logic                                cfg_wr_en,
    input  logic [AW-1:0]                       cfg_wr_addr,
    input  logic [COEFF_WORD_SIZE-1:0]          cfg_wr_data,
    input  logic                                cfg_commit,
    output logic                                cfg_busy,
    output logic                                cfg_err,
    output logic [7:0]                          swap_count,
    input  logic [INPUT_WORD_SIZE-1:0]          s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [N_COEFFS*COEFF_WORD_SIZE-1:0] fir_coeff,
    output logic [INPUT_WORD_SIZE-1:0]          fir_data_in,
    output logic                                fir_valid_in,
    output logic                                flush_active
);

`ifdef FIR_CTRL_FLUSH_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SWAP, ST_FLUSH} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SWAP} state_t;
`endif

    localparam logic [AW:0] N_LIM = (AW+1)'(N_COEFFS);

    state_t                     state_q;
    logic [COEFF_WORD_SIZE-1:0] shadow_q [N_COEFFS];
    logic [COEFF_WORD_SIZE-1:0] active_q [N_COEFFS];
    logic [7:0]                 swap_count_q;
    logic                       cfg_err_q;
    logic                       cfg_err_d;
    logic                       idle;
    logic                       wr_ok;
`ifdef FIR_CTRL_FLUSH_EN
    logic [AW-1:0]              flush_cnt_q;
`endif

    assign idle      = (state_q == ST_IDLE);
    assign wr_ok     = idle && cfg_wr_en && ({1'b0, cfg_wr_addr} < N_LIM);
    assign cfg_err_d = (cfg_wr_en && !wr_ok) || (cfg_commit && !idle);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            swap_count_q <= '0;
            cfg_err_q    <= 1'b0;
            // NOTE: both banks are reset because the filter must see a defined
            // (unity impulse) response straight out of reset.
            for (int i = 0; i < N_COEFFS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= (i == 0) ? COEFF_WORD_SIZE'(1) : '0;
            end
`ifdef FIR_CTRL_FLUSH_EN
            flush_cnt_q  <= '0;
`endif
        end else begin
            cfg_err_q <= cfg_err_d;
            if (wr_ok) shadow_q[cfg_wr_addr] <= cfg_wr_data;

            case (state_q)
                ST_IDLE: if (cfg_commit) state_q <= ST_SWAP;
                ST_SWAP: begin
                    for (int i = 0; i < N_COEFFS; i++) active_q[i] <= shadow_q[i];
                    swap_count_q <= swap_count_q + 8'd1;
`ifdef FIR_CTRL_FLUSH_EN
                    state_q      <= ST_FLUSH;
                    flush_cnt_q  <= AW'(N_COEFFS - 1);
`else
                    state_q      <= ST_IDLE;
`endif
                end
`ifdef FIR_CTRL_FLUSH_EN
                // One zero sample per stale delay-line tap.
                ST_FLUSH: begin
                    if (flush_cnt_q == AW'(1)) begin
                        state_q     <= ST_IDLE;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_COEFFS; g++) begin : g_coeff
        assign fir_coeff[g*COEFF_WORD_SIZE +: COEFF_WORD_SIZE] = active_q[g];
    end

    assign cfg_busy   = !idle;
    assign cfg_err    = cfg_err_q;
    assign swap_count = swap_count_q;
    assign s_ready    = idle;

`ifdef FIR_CTRL_FLUSH_EN
    assign flush_active = (state_q == ST_FLUSH);
`else
    assign flush_active = 1'b0;
`endif

    // Only IDLE forwards upstream samples; a flush injects zeros with valid high.
    assign fir_data_in  = idle ? s_data : '0;
    assign fir_valid_in = idle ? s_valid : flush_active;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed self-checking bench for fir_coeff_ctrl; covers both FIR_CTRL_FLUSH_EN builds.
module tb_fir_coeff_ctrl;
    localparam int W  = 16;
    localparam int C  = 16;
    localparam int N  = 5;
    localparam int AW = $clog2(N);

    logic             clk = 1'b0;
    logic             arst_n;
    logic             cfg_wr_en;
    logic [AW-1:0]    cfg_wr_addr;
    logic [C-1:0]     cfg_wr_data;
    logic             cfg_commit;
    logic             cfg_busy;
    logic             cfg_err;
    logic [7:0]       swap_count;
    logic [W-1:0]     s_data;
    logic             s_valid;
    logic             s_ready;
    logic [N*C-1:0]   fir_coeff;
    logic [W-1:0]     fir_data_in;
    logic             fir_valid_in;
    logic             flush_active;

    int total = 0;
    int bad   = 0;

    fir_coeff_ctrl #(.INPUT_WORD_SIZE(W), .COEFF_WORD_SIZE(C), .N_COEFFS(N)) dut (
        .clk(clk), .arst_n(arst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .swap_count(swap_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fir_coeff(fir_coeff), .fir_data_in(fir_data_in), .fir_valid_in(fir_valid_in),
        .flush_active(flush_active)
    );

    always #5 clk = ~clk;

    // Tap 0 sits in the least-significant coefficient slot.
    function automatic logic [N*C-1:0] bank(input int t0, t1, t2, t3, t4);
        logic [N*C-1:0] v;
        v = '0;
        v[0*C +: C] = C'(t0);
        v[1*C +: C] = C'(t1);
        v[2*C +: C] = C'(t2);
        v[3*C +: C] = C'(t3);
        v[4*C +: C] = C'(t4);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input int data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(addr);
        cfg_wr_data = C'(data);
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!s_ready && n < budget) begin
            step();
            n++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_idle: s_ready=%b required 1 within %0d cycles", s_ready, budget);
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_commit = 1'b0; s_valid = 1'b1; s_data = 16'd100;
        repeat (2) step();
        arst_n = 1'b1;
        #1;
        total++;
        if ({s_ready, cfg_busy, flush_active, fir_valid_in} !== 4'b1001) begin
            bad++; $display("FAIL reset_status: got %b want 1001", {s_ready, cfg_busy, flush_active, fir_valid_in});
        end
        total++;
        if (fir_data_in !== 16'd100) begin
            bad++; $display("FAIL reset_data: got %0d want 100", fir_data_in);
        end
        total++;
        if (fir_coeff !== bank(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_coeff: got %h want %h", fir_coeff, bank(1, 0, 0, 0, 0));
        end
        total++;
        if ({swap_count, cfg_err} !== 9'd0) begin
            bad++; $display("FAIL reset_count_err: got count=%0d err=%b want 0/0", swap_count, cfg_err);
        end
        s_valid = 1'b0; s_data = 16'd3;
        #1;
        total++;
        if ({fir_valid_in, fir_data_in} !== {1'b0, 16'd3}) begin
            bad++; $display("FAIL passthrough: got v=%b d=%0d want v=0 d=3", fir_valid_in, fir_data_in);
        end
    endtask

    task automatic test_swap();
        for (int i = 0; i < N; i++) write(i, i + 1);
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL good_write_err: got %b want 0", cfg_err);
        end
        s_valid = 1'b1; s_data = 16'd77; cfg_commit = 1'b1;
        #1;
        total++;
        if ({fir_valid_in, fir_coeff} !== {1'b1, bank(1, 0, 0, 0, 0)}) begin
            bad++; $display("FAIL commit_edge_old: got v=%b coeff=%h want v=1 unity", fir_valid_in, fir_coeff);
        end
        step();
        cfg_commit = 1'b0;
        total++;
        if ({s_ready, cfg_busy, flush_active, fir_valid_in} !== 4'b0100) begin
            bad++; $display("FAIL swap_status: got %b want 0100", {s_ready, cfg_busy, flush_active, fir_valid_in});
        end
        total++;
        if ({swap_count, fir_coeff} !== {8'd0, bank(1, 0, 0, 0, 0)}) begin
            bad++; $display("FAIL swap_still_old: got count=%0d coeff=%h want 0 unity", swap_count, fir_coeff);
        end
        step();
        total++;
        if ({swap_count, fir_coeff} !== {8'd1, bank(1, 2, 3, 4, 5)}) begin
            bad++; $display("FAIL swap_new: got count=%0d coeff=%h want 1 %h", swap_count, fir_coeff, bank(1, 2, 3, 4, 5));
        end
`ifdef FIR_CTRL_FLUSH_EN
        for (int k = 0; k < N - 1; k++) begin
            total++;
            if ({s_ready, cfg_busy, flush_active, fir_valid_in, fir_data_in} !== {4'b0111, 16'd0}) begin
                bad++; $display("FAIL flush_cycle%0d: got %b d=%0d want 0111 d=0", k,
                                {s_ready, cfg_busy, flush_active, fir_valid_in}, fir_data_in);
            end
            step();
        end
`endif
        total++;
        if ({s_ready, cfg_busy, flush_active, fir_valid_in, fir_data_in} !== {4'b1001, 16'd77}) begin
            bad++; $display("FAIL swap_done: got %b d=%0d want 1001 d=77",
                            {s_ready, cfg_busy, flush_active, fir_valid_in}, fir_data_in);
        end
    endtask

    task automatic test_errors();
        write(7, 99);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++; $display("FAIL bad_addr_err: got %b want 1", cfg_err);
        end
        step();
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL bad_addr_err_clear: got %b want 0", cfg_err);
        end
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        write(0, 55);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++; $display("FAIL busy_write_err: got %b want 1", cfg_err);
        end
`ifdef FIR_CTRL_FLUSH_EN
        total++;
        if (flush_active !== 1'b1) begin
            bad++; $display("FAIL in_flush: got %b want 1", flush_active);
        end
        write(1, 66);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++; $display("FAIL flush_write_err: got %b want 1", cfg_err);
        end
`endif
        step();
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL busy_err_clear: got %b want 0", cfg_err);
        end
        wait_idle(20);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        wait_idle(20);
        total++;
        if ({swap_count, fir_coeff} !== {8'd3, bank(1, 2, 3, 4, 5)}) begin
            bad++; $display("FAIL shadow_kept: got count=%0d coeff=%h want 3 %h", swap_count, fir_coeff, bank(1, 2, 3, 4, 5));
        end
    endtask

    task automatic test_same_cycle();
        cfg_wr_en = 1'b1; cfg_wr_addr = AW'(2); cfg_wr_data = C'(9); cfg_commit = 1'b1;
        step();
        cfg_wr_en = 1'b0;
        step();
        cfg_commit = 1'b0;
        total++;
        if (cfg_err !== 1'b1) begin
            bad++; $display("FAIL busy_commit_err: got %b want 1", cfg_err);
        end
        total++;
        if ({swap_count, fir_coeff} !== {8'd4, bank(1, 2, 9, 4, 5)}) begin
            bad++; $display("FAIL same_cycle_swap: got count=%0d coeff=%h want 4 %h", swap_count, fir_coeff, bank(1, 2, 9, 4, 5));
        end
        wait_idle(20);
        repeat (3) step();
        total++;
        if ({swap_count, cfg_err, cfg_busy} !== {8'd4, 2'b00}) begin
            bad++; $display("FAIL single_swap: got count=%0d err=%b busy=%b want 4/0/0", swap_count, cfg_err, cfg_busy);
        end
    endtask

    task automatic test_reset_mid();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
`ifdef FIR_CTRL_FLUSH_EN
        step();
`endif
        total++;
        if (cfg_busy !== 1'b1) begin
            bad++; $display("FAIL pre_reset_busy: got %b want 1", cfg_busy);
        end
        arst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, cfg_busy, flush_active, fir_valid_in} !== 4'b1001) begin
            bad++; $display("FAIL mid_reset_status: got %b want 1001", {s_ready, cfg_busy, flush_active, fir_valid_in});
        end
        total++;
        if ({swap_count, fir_coeff} !== {8'd0, bank(1, 0, 0, 0, 0)}) begin
            bad++; $display("FAIL mid_reset_bank: got count=%0d coeff=%h want 0 unity", swap_count, fir_coeff);
        end
        step();
        arst_n = 1'b1;
        repeat (2) step();
        total++;
        if ({s_ready, swap_count, fir_coeff} !== {1'b1, 8'd0, bank(1, 0, 0, 0, 0)}) begin
            bad++; $display("FAIL post_reset: got rdy=%b count=%0d coeff=%h want 1 0 unity", s_ready, swap_count, fir_coeff);
        end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 256; i++) begin
            cfg_commit = 1'b1;
            step();
            cfg_commit = 1'b0;
            wait_idle(20);
            if (i == 255) begin
                total++;
                if (swap_count !== 8'd255) begin
                    bad++; $display("FAIL count_255: got %0d want 255", swap_count);
                end
            end
        end
        total++;
        if ({swap_count, fir_coeff} !== {8'd0, bank(0, 0, 0, 0, 0)}) begin
            bad++; $display("FAIL count_wrap: got count=%0d coeff=%h want 0 all-zero", swap_count, fir_coeff);
        end
    endtask

    initial begin
        test_reset();
        test_swap();
        test_errors();
        test_same_cycle();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
